// File: rtl/mix_columns_seq.sv
// Forward AES MixColumns engine. A 128-bit state is accepted over a valid/ready
// handshake, COLS_PER_CYCLE columns are mixed per clock in a work register, and
// the result is held until the downstream stage takes it. The bypass input
// carries the final round, which has no MixColumns, with identical latency.

// One column of MixColumns, pure combinational.
module mix_col (
   input  logic [31:0] col_in,
   output logic [31:0] col_out
);
   function automatic logic [7:0] xtime(input logic [7:0] x);
      return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
   endfunction

   logic [7:0] a0, a1, a2, a3;
   logic [7:0] x0, x1, x2, x3;

   assign a0 = col_in[31:24];
   assign a1 = col_in[23:16];
   assign a2 = col_in[15:8];
   assign a3 = col_in[7:0];

   assign x0 = xtime(a0);
   assign x1 = xtime(a1);
   assign x2 = xtime(a2);
   assign x3 = xtime(a3);

   // 3x is computed as xtime(x) ^ x.
   assign col_out = {x0 ^ x1 ^ a1 ^ a2 ^ a3,
                     a0 ^ x1 ^ x2 ^ a2 ^ a3,
                     a0 ^ a1 ^ x2 ^ x3 ^ a3,
                     x0 ^ a0 ^ a1 ^ a2 ^ x3};
endmodule

module mix_columns_seq #(
   parameter int COLS_PER_CYCLE = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] state_in,
   input  logic         bypass,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] state_out
);
   localparam int LANES = COLS_PER_CYCLE;

   generate
      if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cols
         $fatal(1, "mix_columns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
      end
   endgenerate

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t               state_q, state_d;
   logic [3:0][31:0]     work_q, work_d;
   logic                 bypass_q;
   logic [1:0]           col_cnt;
   logic [2:0]           cnt_sum;
   logic                 last_step;
   logic                 accept;

   logic [LANES-1:0][1:0]  lane_col;
   logic [LANES-1:0][31:0] lane_in;
   logic [LANES-1:0][31:0] lane_out;

   // Bit 2 of the sum marks the step that finishes column 3; the low bits wrap
   // back to 0, so col_cnt never leaves 0..3.
   assign cnt_sum   = {1'b0, col_cnt} + 3'(COLS_PER_CYCLE);
   assign last_step = cnt_sum[2];
   assign accept    = in_valid & in_ready;
   assign state_out = work_q;

   // One mixer per lane; lane j works on column col_cnt + j (low column first).
   genvar j;
   generate
      for (j = 0; j < LANES; j++) begin : g_lane
         assign lane_col[j] = col_cnt + 2'(j);
         assign lane_in[j]  = work_q[lane_col[j]];
         mix_col u_mix (.col_in(lane_in[j]), .col_out(lane_out[j]));
      end
   endgenerate

   // Write the mixed lanes back over their columns; bypass leaves them as-is.
   always_comb begin
      work_d = work_q;
      if (!bypass_q) begin
         for (int k = 0; k < LANES; k++) begin
            work_d[lane_col[k]] = lane_out[k];
         end
      end
   end

   // Next-state and handshake outputs.
   always_comb begin
      state_d   = state_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_d = BUSY;
         end
         BUSY: begin
            if (last_step) state_d = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            in_ready  = out_ready;
            if (out_ready) state_d = in_valid ? BUSY : IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Work register: load on accept, advance one column group per BUSY clock.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         work_q   <= '0;
         bypass_q <= 1'b0;
         col_cnt  <= 2'd0;
      end else if (accept) begin
         work_q   <= state_in;
         bypass_q <= bypass;
         col_cnt  <= 2'd0;
      end else if (state_q == BUSY) begin
         work_q   <= work_d;
         col_cnt  <= cnt_sum[1:0];
      end
   end
endmodule

// File: doc/mix_columns_seq.md
Name: mix_columns_seq

Overview:
- Forward AES MixColumns engine: the encrypt-side counterpart of the inverse MixColumns stage.
- Accepts a 128-bit state over a valid/ready handshake and mixes COLS_PER_CYCLE columns per clock.
- Holds the result until the downstream stage takes it.
- Sits between ShiftRows and AddRoundKey in the round datapath. The bypass input serves the final round, which has no MixColumns.

Parameters:
- COLS_PER_CYCLE, 1, columns mixed per clock. Legal values are 1, 2 and 4; any other value is a fatal elaboration error.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  state_in and bypass are valid
- in_ready  output  1  block can accept a new state
- state_in  input  128  input state; column i = bits [i*32 +: 32], byte a0 at [i*32+24 +: 8], a1 at +16, a2 at +8, a3 at +0
- bypass  input  1  sampled with state_in; 1 = pass the state through unmixed with identical latency
- out_valid  output  1  state_out holds a completed result
- out_ready  input  1  downstream accepts state_out
- state_out  output  128  result, same byte/column mapping as state_in

Behaviour:
- Arithmetic, per column, in GF(2^8):
  - b0 = 2a0^3a1^a2^a3
  - b1 = a0^2a1^3a2^a3
  - b2 = a0^a1^2a2^3a3
  - b3 = 3a0^a1^a2^2a3
  - xtime(x) = (x<<1) ^ (x[7] ? 8'h1b : 8'h00), truncated to 8 bits
  - 3x = xtime(x) ^ x
- FSM states:
  - IDLE: in_ready=1, out_valid=0.
  - BUSY: in_ready=0, out_valid=0.
  - DONE: out_valid=1, in_ready=out_ready.
- IDLE to BUSY on accept (in_valid & in_ready). On that edge: work register <= state_in, bypass_q <= bypass, col_cnt <= 0.
- BUSY, each edge:
  - Columns col_cnt .. col_cnt+COLS_PER_CYCLE-1 of the work register are replaced by their mixed value. Columns are processed low column first. If bypass_q=1, they are left unchanged.
  - col_cnt advances by COLS_PER_CYCLE.
  - On the edge that completes column 3: go to DONE and set out_valid=1.
- Latency: out_valid rises 4/COLS_PER_CYCLE clocks after the accepting edge (4, 2 or 1). Throughput is one state per 4/COLS_PER_CYCLE+1 clocks.
- DONE:
  - out_valid & out_ready & ~in_valid: go to IDLE and clear out_valid.
  - out_valid & out_ready & in_valid: the result is consumed and the new state is accepted on the same edge. Go to BUSY and load per the accept rule.
  - ~out_ready: hold. state_out and out_valid stay stable and in_ready=0. in_valid is ignored.
- state_out is the work register. It is defined only while out_valid=1 and may change in BUSY. The bench checks it only under out_valid.
- col_cnt never exceeds 3. It is reloaded to 0 on every accept.
- in_valid and bypass are ignored in BUSY. No input buffering is done.
- Reset (rst_n low, asynchronous, any state including mid-BUSY):
  - state=IDLE, col_cnt=0, bypass_q=0, work register=0.
  - out_valid=0, state_out=128'h0, in_ready=1.
  - Any in-flight state is discarded.
- Deassertion of rst_n is synchronised externally; the first accept can occur on the first edge after release.

Test Plan:
- FIPS-197 vector, COLS_PER_CYCLE=1, bypass=0: state_in=db135345_f20a225c_01010101_2d26314c -> state_out=8e4da1bc_9fdc589d_01010101_4d7ebdf8, out_valid exactly 4 clocks after accept.
- Same vector with COLS_PER_CYCLE=2 and COLS_PER_CYCLE=4 -> identical state_out; latency 2 and 1 clocks respectively.
- bypass=1, state_in=00112233_44556677_8899aabb_ccddeeff -> state_out equals state_in after the same 4-clock latency.
- Backpressure: hold out_ready=0 for 10 clocks after out_valid, with in_valid=1 throughout -> state_out stable, in_ready=0, nothing accepted. Raise out_ready -> result consumed and next state (c6c6c6c6_d4d4d4d5_01010101_f20a225c) accepted on the same edge. Its result c6c6c6c6_d5d5d7d6_01010101_9fdc589d appears 4 clocks later.
- Reset mid-BUSY: assert rst_n low 2 clocks after accept -> immediately out_valid=0, state_out=0, in_ready=1. After release, no stale result appears, and a fresh accept produces the correct result.
- Random regression: 10k random states with random bypass and random in_valid/out_ready gaps -> every result matches the reference model, in order, with no drops or duplicates.
